fifo_wr_adapter: RTL and testbench
==================================

FIFO_WR_ADAPTER -- requirements
Module: fifo_wr_adapter

Interface
REQ-001 Parameter: DSIZE, 8, data word width in bits.
REQ-002 Parameter: CNTW, 16, width of the statistics counters.
REQ-003 wclk  input  1  write-domain clock; all state changes on its rising edge.
REQ-004 wrst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_data  input  DSIZE  upstream word.
REQ-007 in_ready  output  1  adapter can accept a word this cycle.
REQ-008 wfull  input  1  registered full flag from the FIFO write-pointer stage.
REQ-009 winc  output  1  write strobe to the FIFO write port.
REQ-010 wdata  output  DSIZE  word to the FIFO memory write port.
REQ-011 clr  input  1  synchronous flush of buffer and counters.
REQ-012 wr_count  output  CNTW  FIFO writes issued, wrapping.
REQ-013 stall_count  output  CNTW  cycles with a pending word blocked by wfull, saturating.

Function
REQ-014 The adapter SHALL hold a 2-entry in-order skid buffer with states EMPTY, ONE, TWO.
REQ-015 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, driven from registered state only (no combinational path from wfull).
REQ-016 A word SHALL be accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-017 winc SHALL be 1 exactly when state is not EMPTY and wfull is 0; wdata SHALL equal the oldest buffered word.
REQ-018 wdata SHALL hold its value while winc is 0 and state is not EMPTY.
REQ-019 Transitions: EMPTY->ONE on accept; ONE->TWO on accept without winc; ONE->EMPTY on winc without accept; TWO->ONE on winc; all other cases hold state.
REQ-020 Simultaneous accept and winc in ONE SHALL keep ONE, with the new word becoming head on the next cycle.
REQ-021 Latency: a word accepted at edge N into EMPTY SHALL appear on wdata with winc=1 in the cycle after edge N if wfull=0.
REQ-022 Word order at wdata SHALL equal acceptance order; no word SHALL be dropped or duplicated.
REQ-023 wr_count SHALL increment by 1 on every edge where winc=1 and wrap from 2^CNTW-1 to 0.
REQ-024 stall_count SHALL increment on every edge where state is not EMPTY and wfull=1, and saturate at 2^CNTW-1.
REQ-025 clr=1 SHALL force EMPTY and zero both counters at the next edge, discarding buffered words and ignoring any accept or winc in that cycle.
REQ-026 While clr=1, in_ready SHALL be 0.
REQ-027 If wfull deasserts while in TWO, the adapter SHALL drain one word per cycle until wfull rises again or state is EMPTY.

Reset
REQ-028 While wrst_n=0: state EMPTY, in_ready=0, winc=0, wdata=0, wr_count=0, stall_count=0.
REQ-029 in_ready SHALL become 1 on the first rising edge after wrst_n deasserts.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered words immediately, with no winc pulse on reset release.

Structure
REQ-031 The state enum (EMPTY, ONE, TWO) SHALL reside in the shared FIFO package with the existing FIFO constants.
REQ-032 The skid buffer SHALL be a sub-module named skid_buf2; counters and winc gating remain in the top.

Verification
REQ-033 Reset, then in_valid=1 with data 0xA5 for one cycle, wfull=0 -> next cycle winc=1, wdata=0xA5, wr_count=1.
REQ-034 wfull=1 held; push 0x11, 0x22 -> in_ready=0 after the second accept, winc=0, stall_count increments each cycle; release wfull -> wdata 0x11 then 0x22 on consecutive cycles.
REQ-035 Continuous in_valid with incrementing data 0x00..0xFF, wfull=0 -> 256 consecutive winc pulses in order, wr_count=256.
REQ-036 wfull toggling randomly for 1000 cycles with random in_valid -> wdata sequence matches the accepted sequence exactly.
REQ-037 State TWO holding 0x33, 0x44; assert clr for one cycle -> next cycle state EMPTY, winc=0, counters 0, neither word ever written.
REQ-038 CNTW=4, wfull held 20 cycles with a pending word -> stall_count stops at 15; 17 writes -> wr_count=1.

Source files
------------

// File: rtl/fifo_wr_adapter_pkg.sv
// Shared FIFO definitions: default widths and the write-adapter skid-buffer state.
package fifo_wr_adapter_pkg;

    localparam int FIFO_DSIZE = 8;
    localparam int FIFO_CNTW  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/fifo_wr_adapter_skid_buf2.sv
// Two-entry in-order skid buffer; head is always the oldest buffered word.
module skid_buf2
    import fifo_wr_adapter_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output skid_state_e      state,
    output logic [DSIZE-1:0] head
);

    skid_state_e      state_d, state_q;
    logic [DSIZE-1:0] head_d, head_q;
    logic [DSIZE-1:0] tail_d, tail_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_d  = push_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = push_data;
                    end else if (push) begin
                        tail_d  = push_data;
                        state_d = TWO;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: the data registers are reset too, because wdata must read 0 while reset is held.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign state = state_q;
    assign head  = head_q;

endmodule

// File: rtl/fifo_wr_adapter.sv
// FIFO write-port adapter: skid buffer in front of the FIFO write port, plus write/stall statistics.
module fifo_wr_adapter
    import fifo_wr_adapter_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE,
    parameter int CNTW  = FIFO_CNTW
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             in_valid,
    input  logic [DSIZE-1:0] in_data,
    output logic             in_ready,
    input  logic             wfull,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    input  logic             clr,
    output logic [CNTW-1:0]  wr_count,
    output logic [CNTW-1:0]  stall_count
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    skid_state_e     state;
    logic            pending;
    logic            accept;
    logic            live_d, live_q;
    logic [CNTW-1:0] wr_count_d, wr_count_q;
    logic [CNTW-1:0] stall_count_d, stall_count_q;

    // live_q keeps in_ready low until the first edge after reset release.
    assign live_d   = 1'b1;
    assign pending  = (state != EMPTY);
    assign in_ready = live_q && (state != TWO) && !clr;
    assign accept   = in_valid && in_ready;
    assign winc     = pending && !wfull && !clr;

    skid_buf2 #(
        .DSIZE(DSIZE)
    ) u_skid (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .flush     (clr),
        .push      (accept),
        .push_data (in_data),
        .pop       (winc),
        .state     (state),
        .head      (wdata)
    );

    always_comb begin
        wr_count_d    = wr_count_q;
        stall_count_d = stall_count_q;
        if (clr) begin
            wr_count_d    = '0;
            stall_count_d = '0;
        end else begin
            if (winc) begin
                wr_count_d = wr_count_q + CNTW'(1);
            end
            if (pending && wfull && (stall_count_q != CNT_MAX)) begin
                stall_count_d = stall_count_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            live_q        <= 1'b0;
            wr_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            live_q        <= live_d;
            wr_count_q    <= wr_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign wr_count    = wr_count_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fifo_wr_adapter.sv
// Directed and randomized checks of fifo_wr_adapter; a CNTW=4 copy shares the stimulus for wrap/saturation.
module tb_fifo_wr_adapter;

    logic       wclk;
    logic       wrst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       wfull;
    logic       clr;

    logic        in_ready, winc;
    logic [7:0]  wdata;
    logic [15:0] wr_count, stall_count;

    logic        in_ready4, winc4;
    logic [7:0]  wdata4;
    logic [3:0]  wr_count4, stall_count4;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    int         exp_writes;
    int         exp_stalls;
    logic       exp_winc;
    logic       exp_ready;

    fifo_wr_adapter #(.DSIZE(8), .CNTW(16)) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wfull       (wfull),
        .winc        (winc),
        .wdata       (wdata),
        .clr         (clr),
        .wr_count    (wr_count),
        .stall_count (stall_count)
    );

    fifo_wr_adapter #(.DSIZE(8), .CNTW(4)) dut4 (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready4),
        .wfull       (wfull),
        .winc        (winc4),
        .wdata       (wdata4),
        .clr         (clr),
        .wr_count    (wr_count4),
        .stall_count (stall_count4)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    initial begin
        wrst_n   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        wfull    = 1'b0;
        clr      = 1'b0;

        // Reset state
        #12;
        check("rst_ready", in_ready, 0);
        check("rst_winc", winc, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_stall_count", stall_count, 0);
        check("rst_ready4", in_ready4, 0);
        @(negedge wclk);
        wrst_n = 1'b1;
        #1;
        check("release_ready_low", in_ready, 0);
        tick();
        check("release_ready_high", in_ready, 1);

        // Single word, first-cycle latency
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #1;
        check("t1_ready", in_ready, 1);
        check("t1_winc_before", winc, 0);
        tick();
        in_valid = 1'b0;
        #1;
        check("t1_winc", winc, 1);
        check("t1_wdata", wdata, 8'hA5);
        check("t1_wdata4", wdata4, 8'hA5);
        tick();
        check("t1_wr_count", wr_count, 1);
        check("t1_winc_after", winc, 0);

        // Fill to TWO under wfull, then drain in order
        wfull    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h11;
        #1;
        check("t2_ready0", in_ready, 1);
        check("t2_winc0", winc, 0);
        tick();
        in_data = 8'h22;
        #1;
        check("t2_ready1", in_ready, 1);
        check("t2_stall1", stall_count, 0);
        tick();
        in_valid = 1'b0;
        #1;
        check("t2_ready_full", in_ready, 0);
        check("t2_winc_full", winc, 0);
        check("t2_wdata_hold", wdata, 8'h11);
        check("t2_stall2", stall_count, 1);
        tick();
        check("t2_stall3", stall_count, 2);
        check("t2_wdata_hold2", wdata, 8'h11);
        tick();
        check("t2_stall4", stall_count, 3);
        wfull = 1'b0;
        #1;
        check("t2_drain_winc0", winc, 1);
        check("t2_drain_wdata0", wdata, 8'h11);
        check("t2_drain_ready0", in_ready, 0);
        tick();
        check("t2_drain_winc1", winc, 1);
        check("t2_drain_wdata1", wdata, 8'h22);
        check("t2_drain_ready1", in_ready, 1);
        check("t2_wr_count1", wr_count, 2);
        check("t2_stall_frozen", stall_count, 3);
        tick();
        check("t2_winc_empty", winc, 0);
        check("t2_wr_count2", wr_count, 3);

        // Flush counters
        clr = 1'b1;
        #1;
        check("clr_ready", in_ready, 0);
        tick();
        clr = 1'b0;
        #1;
        check("clr_wr_count", wr_count, 0);
        check("clr_stall_count", stall_count, 0);

        // 256-word back-to-back burst
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            #1;
            check("burst_ready", in_ready, 1);
            if (i > 0) begin
                check("burst_winc", winc, 1);
                check("burst_wdata", wdata, 32'(i - 1));
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("burst_last_winc", winc, 1);
        check("burst_last_wdata", wdata, 8'hFF);
        tick();
        check("burst_idle", winc, 0);
        check("burst_wr_count", wr_count, 256);
        check("burst_wr_count4", wr_count4, 0);

        // Flush discards a full buffer
        wfull    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        tick();
        in_data = 8'h44;
        tick();
        in_valid = 1'b0;
        #1;
        check("t4_ready_two", in_ready, 0);
        check("t4_wdata_two", wdata, 8'h33);
        check("t4_stall", stall_count, 1);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        #1;
        check("t4_clr_ready", in_ready, 0);
        check("t4_clr_winc", winc, 0);
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        wfull    = 1'b0;
        #1;
        check("t4_post_winc", winc, 0);
        check("t4_post_ready", in_ready, 1);
        check("t4_post_wr_count", wr_count, 0);
        check("t4_post_stall", stall_count, 0);
        tick();
        check("t4_post_winc2", winc, 0);
        check("t4_post_wr_count2", wr_count, 0);

        // Saturation and wrap on the narrow-counter copy
        wfull    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("sat_stall16", stall_count, 20);
        check("sat_stall4", stall_count4, 15);
        wfull = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h80 + i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("wrap_last_winc", winc, 1);
        check("wrap_last_wdata", wdata, 8'h8F);
        tick();
        check("wrap_wr_count16", wr_count, 17);
        check("wrap_wr_count4", wr_count4, 1);
        check("wrap_stall4_held", stall_count4, 15);

        // Reset asserted mid-transfer
        wfull    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h91;
        tick();
        in_data = 8'h92;
        tick();
        in_valid = 1'b0;
        #1;
        check("mid_ready_two", in_ready, 0);
        wrst_n = 1'b0;
        #1;
        check("mid_rst_winc", winc, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_wdata", wdata, 0);
        check("mid_rst_wr_count", wr_count, 0);
        check("mid_rst_stall", stall_count, 0);
        wfull = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;
        #1;
        check("mid_rel_winc", winc, 0);
        check("mid_rel_ready", in_ready, 0);
        tick();
        check("mid_rel_winc2", winc, 0);
        check("mid_rel_ready2", in_ready, 1);
        tick();
        check("mid_rel_winc3", winc, 0);

        // Random wfull / in_valid against a queue model
        exp_writes = 0;
        exp_stalls = 0;
        for (int c = 0; c < 1000; c++) begin
            wfull    = ($urandom_range(0, 1) == 1);
            in_valid = ($urandom_range(0, 1) == 1);
            in_data  = 8'($urandom);
            #1;
            exp_winc  = (q.size() != 0) && !wfull;
            exp_ready = (q.size() < 2);
            check("rnd_winc", winc, exp_winc);
            check("rnd_winc4", winc4, exp_winc);
            check("rnd_ready", in_ready, exp_ready);
            if (q.size() != 0) begin
                check("rnd_wdata", wdata, q[0]);
            end
            if ((q.size() != 0) && wfull) begin
                exp_stalls++;
            end
            if (exp_winc) begin
                void'(q.pop_front());
                exp_writes++;
            end
            if (in_valid && exp_ready) begin
                q.push_back(in_data);
            end
            tick();
        end
        wfull    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            exp_winc = (q.size() != 0);
            check("drain_winc", winc, exp_winc);
            if (exp_winc) begin
                check("drain_wdata", wdata, q[0]);
                void'(q.pop_front());
                exp_writes++;
            end
            tick();
        end
        check("rnd_final_idle", winc, 0);
        check("rnd_wr_count", wr_count, 32'(exp_writes % 65536));
        check("rnd_wr_count4", wr_count4, 32'(exp_writes % 16));
        check("rnd_stall_count", stall_count, 32'((exp_stalls > 65535) ? 65535 : exp_stalls));
        check("rnd_stall_count4", stall_count4, 32'((exp_stalls > 15) ? 15 : exp_stalls));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
